// File: rtl/vga_blit_engine_if.sv
`default_nettype none
// ============================================================================
// vga_blit_engine_if : register, source-RAM and VRAM bus bundle of the blitter
// Revision           : 1.0
// ============================================================================
interface vga_blit_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              i_reg_we;
  logic [3:0]        i_reg_addr;
  logic [7:0]        i_reg_data;
  logic              o_src_re;
  logic [ADDR_W-1:0] o_src_addr;
  logic [DATA_W-1:0] i_src_data;
  logic              o_dst_we_b;
  logic [ADDR_W-1:0] o_dst_addr;
  logic [DATA_W-1:0] o_dst_data;
  logic              i_free_vbus_b;
  logic              o_active;
  logic              o_done;

  modport master (
    output i_reg_we, i_reg_addr, i_reg_data, i_src_data, i_free_vbus_b,
    input  o_src_re, o_src_addr, o_dst_we_b, o_dst_addr, o_dst_data, o_active, o_done
  );

  modport slave (
    input  i_reg_we, i_reg_addr, i_reg_data, i_src_data, i_free_vbus_b,
    output o_src_re, o_src_addr, o_dst_we_b, o_dst_addr, o_dst_data, o_active, o_done
  );
endinterface
`default_nettype wire

// File: rtl/vga_blit_engine.sv
`default_nettype none
// ============================================================================
// vga_blit_engine : register-programmed 2-D blitter (copy / fill / key-copy)
// Revision        : 1.0
// ============================================================================
module vga_blit_engine #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 8,
  parameter int SRC_LAT = 1
) (
  input logic              i_clk,
  input logic              i_rst,
  vga_blit_engine_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_ADV   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int                 C_LAT_W    = 3;
  localparam logic [C_LAT_W-1:0] C_LAT_LAST = C_LAT_W'(SRC_LAT - 1);
  localparam logic [3:0] C_REG_SRC_LO     = 4'd0;
  localparam logic [3:0] C_REG_SRC_HI     = 4'd1;
  localparam logic [3:0] C_REG_DST_LO     = 4'd2;
  localparam logic [3:0] C_REG_DST_HI     = 4'd3;
  localparam logic [3:0] C_REG_WIDTH      = 4'd4;
  localparam logic [3:0] C_REG_HEIGHT     = 4'd5;
  localparam logic [3:0] C_REG_MASK       = 4'd6;
  localparam logic [3:0] C_REG_CTRL       = 4'd7;
  localparam logic [3:0] C_REG_KEY        = 4'd8;
  localparam logic [3:0] C_REG_SRC_STRIDE = 4'd9;
  localparam logic [3:0] C_REG_DST_STRIDE = 4'd10;
  localparam logic [1:0] C_MODE_FILL      = 2'd1;
  localparam logic [1:0] C_MODE_KEY       = 2'd2;

  state_t r_state, w_state_next;

  logic [7:0]         r_src_lo, r_src_hi, r_dst_lo, r_dst_hi;
  logic [LEN_W-1:0]   r_width, r_height, r_src_stride, r_dst_stride;
  logic [DATA_W-1:0]  r_mask, r_key;

  logic [LEN_W-1:0]   r_w, r_h, r_col, r_row, r_ss, r_ds;
  logic [DATA_W-1:0]  r_mask_l, r_key_l, r_data;
  logic [1:0]         r_mode_l;
  logic [ADDR_W-1:0]  r_src_ptr, r_src_row, r_dst_ptr, r_dst_row;
  logic [C_LAT_W-1:0] r_lat_cnt;

  logic              w_ctrl_wr, w_abort, w_start, w_cfg_wr, w_empty;
  logic              w_fill, w_skip, w_col_last, w_row_last;
  logic [1:0]        w_start_mode;
  logic [ADDR_W-1:0] w_src_base, w_dst_base, w_src_row_next, w_dst_row_next;
  logic              w_src_re, w_dst_we_b, w_active, w_done;

  assign w_ctrl_wr      = bus.i_reg_we && (bus.i_reg_addr == C_REG_CTRL);
  assign w_abort        = w_ctrl_wr && bus.i_reg_data[7];
  assign w_start        = w_ctrl_wr && bus.i_reg_data[0] && !bus.i_reg_data[7] && (r_state == S_IDLE);
  assign w_start_mode   = bus.i_reg_data[2:1];
  assign w_cfg_wr       = bus.i_reg_we && !w_active;
  assign w_empty        = (r_width == '0) || (r_height == '0);
  assign w_fill         = (r_mode_l == C_MODE_FILL);
  // Key match is judged on the raw source pixel, before masking.
  assign w_skip         = (r_mode_l == C_MODE_KEY) && (r_data == r_key_l);
  assign w_col_last     = ((r_col + LEN_W'(1)) == r_w);
  assign w_row_last     = ((r_row + LEN_W'(1)) == r_h);
  assign w_src_base     = ADDR_W'({r_src_hi, r_src_lo});
  assign w_dst_base     = ADDR_W'({r_dst_hi, r_dst_lo});
  assign w_src_row_next = r_src_row + ADDR_W'(r_w) + ADDR_W'(r_ss);
  assign w_dst_row_next = r_dst_row + ADDR_W'(r_w) + ADDR_W'(r_ds);

  assign bus.o_src_re   = w_src_re;
  assign bus.o_src_addr = r_src_ptr;
  assign bus.o_dst_we_b = w_dst_we_b;
  assign bus.o_dst_addr = r_dst_ptr;
  assign bus.o_dst_data = (w_fill ? r_key_l : r_data) & r_mask_l;
  assign bus.o_active   = w_active;
  assign bus.o_done     = w_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_src_re     = 1'b0;
    w_dst_we_b   = 1'b1;
    w_active     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_empty)                         w_state_next = S_DONE;
          else if (w_start_mode == C_MODE_FILL) w_state_next = S_WRITE;
          else                                 w_state_next = S_READ;
        end
      end
      S_READ: begin
        w_active     = 1'b1;
        w_src_re     = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_active = 1'b1;
        if (r_lat_cnt == C_LAT_LAST) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_active = 1'b1;
        if (!bus.i_free_vbus_b) begin
          w_dst_we_b   = w_skip;
          w_state_next = S_ADV;
        end
      end
      S_ADV: begin
        w_active = 1'b1;
        if (w_col_last && w_row_last) w_state_next = S_DONE;
        else if (w_fill)              w_state_next = S_WRITE;
        else                          w_state_next = S_READ;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // A strobe issued this cycle still completes; nothing follows it.
    if (w_active && w_abort) w_state_next = S_DONE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_src_lo     <= '0;
      r_src_hi     <= '0;
      r_dst_lo     <= '0;
      r_dst_hi     <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_src_stride <= '0;
      r_dst_stride <= '0;
      r_mask       <= '0;
      r_key        <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_ss         <= '0;
      r_ds         <= '0;
      r_mask_l     <= '0;
      r_key_l      <= '0;
      r_data       <= '0;
      r_mode_l     <= '0;
      r_src_ptr    <= '0;
      r_src_row    <= '0;
      r_dst_ptr    <= '0;
      r_dst_row    <= '0;
      r_lat_cnt    <= '0;
    end else begin
      if (w_cfg_wr) begin
        case (bus.i_reg_addr)
          C_REG_SRC_LO:     r_src_lo     <= bus.i_reg_data;
          C_REG_SRC_HI:     r_src_hi     <= bus.i_reg_data;
          C_REG_DST_LO:     r_dst_lo     <= bus.i_reg_data;
          C_REG_DST_HI:     r_dst_hi     <= bus.i_reg_data;
          C_REG_WIDTH:      r_width      <= LEN_W'(bus.i_reg_data);
          C_REG_HEIGHT:     r_height     <= LEN_W'(bus.i_reg_data);
          C_REG_MASK:       r_mask       <= DATA_W'(bus.i_reg_data);
          C_REG_KEY:        r_key        <= DATA_W'(bus.i_reg_data);
          C_REG_SRC_STRIDE: r_src_stride <= LEN_W'(bus.i_reg_data);
          C_REG_DST_STRIDE: r_dst_stride <= LEN_W'(bus.i_reg_data);
          default: ;
        endcase
      end
      if (w_start) begin
        r_w       <= r_width;
        r_h       <= r_height;
        r_ss      <= r_src_stride;
        r_ds      <= r_dst_stride;
        r_mask_l  <= r_mask;
        r_key_l   <= r_key;
        r_mode_l  <= w_start_mode;
        r_col     <= '0;
        r_row     <= '0;
        r_src_ptr <= w_src_base;
        r_src_row <= w_src_base;
        r_dst_ptr <= w_dst_base;
        r_dst_row <= w_dst_base;
      end
      case (r_state)
        S_READ: r_lat_cnt <= '0;
        S_WAIT: begin
          if (r_lat_cnt == C_LAT_LAST) r_data <= bus.i_src_data;
          else                         r_lat_cnt <= r_lat_cnt + C_LAT_W'(1);
        end
        S_ADV: begin
          if (w_col_last) begin
            r_col     <= '0;
            r_row     <= r_row + LEN_W'(1);
            r_src_row <= w_src_row_next;
            r_src_ptr <= w_src_row_next;
            r_dst_row <= w_dst_row_next;
            r_dst_ptr <= w_dst_row_next;
          end else begin
            r_col     <= r_col + LEN_W'(1);
            r_src_ptr <= r_src_ptr + ADDR_W'(1);
            r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vga_blit_engine.sv
`default_nettype none
// tb_vga_blit_engine: directed and randomized blits checked against a
// rectangle-walking reference model of the expected bus traffic.
module tb_vga_blit_engine;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 8;
  localparam int SRC_LAT = 1;
  localparam int PIX_CYC = SRC_LAT + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [7:0]        src_mem [0:65535];
  logic [ADDR_W-1:0] lat_pipe [SRC_LAT];
  int exp_wr[$], got_wr[$], exp_rd[$], got_rd[$];

  vga_blit_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_blit_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SRC_LAT(SRC_LAT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Source RAM: data for an address presented at a read appears SRC_LAT cycles later.
  always @(posedge clk) begin
    lat_pipe[0] <= bus.o_src_addr;
    for (int i = 1; i < SRC_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
  end
  assign bus.i_src_data = src_mem[lat_pipe[SRC_LAT-1]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
    bus.i_reg_we   = 1'b1;
    bus.i_reg_addr = a;
    bus.i_reg_data = d;
    @(negedge clk);
    bus.i_reg_we   = 1'b0;
  endtask

  task automatic program_regs(input int src, input int dst, input int w, input int h,
                              input int ss, input int ds, input int mask, input int key);
    reg_write(4'd0, 8'(src));      reg_write(4'd1, 8'(src >> 8));
    reg_write(4'd2, 8'(dst));      reg_write(4'd3, 8'(dst >> 8));
    reg_write(4'd4, 8'(w));        reg_write(4'd5, 8'(h));
    reg_write(4'd6, 8'(mask));     reg_write(4'd8, 8'(key));
    reg_write(4'd9, 8'(ss));       reg_write(4'd10, 8'(ds));
  endtask

  // Walk the rectangle row by row and list every read and every visible write.
  task automatic build_model(input int src, input int dst, input int w, input int h,
                             input int ss, input int ds, input int mask, input int key,
                             input int mode);
    int s, d, pix;
    exp_wr.delete();
    exp_rd.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        s = (src + r * (w + ss) + c) % 65536;
        d = (dst + r * (w + ds) + c) % 65536;
        if (mode == 1) pix = key;
        else begin
          pix = int'(src_mem[s]);
          exp_rd.push_back(s);
        end
        if (!(mode == 2 && pix == key)) exp_wr.push_back((d << 8) | (pix & mask));
      end
  endtask

  task automatic do_blit(input string tag, input bit reprogram,
                         input int src, input int dst, input int w, input int h,
                         input int ss, input int ds, input int mask, input int key,
                         input int mode, input int stall_until, input int stall_extra,
                         input int abort_at, input int poke_at);
    int cyc, act, stall_bad, strobes, exp_act, cur;
    bit seen_done, abort_next;
    if (reprogram) program_regs(src, dst, w, h, ss, ds, mask, key);
    build_model(src, dst, w, h, ss, ds, mask, key, mode);
    exp_act = w * h * ((mode == 1) ? 2 : PIX_CYC) + stall_extra;
    if (abort_at > 0) begin
      while (exp_wr.size() > abort_at) void'(exp_wr.pop_back());
      while (exp_rd.size() > abort_at) void'(exp_rd.pop_back());
      exp_act = abort_at * ((mode == 1) ? 2 : PIX_CYC);
    end
    got_wr.delete();
    got_rd.delete();
    cyc = 0; act = 0; stall_bad = 0; strobes = 0;
    seen_done = 1'b0; abort_next = 1'b0;
    reg_write(4'd7, 8'((mode << 1) | 1));
    while (!seen_done && cyc < 3000) begin
      bus.i_free_vbus_b = (cyc < stall_until);
      bus.i_reg_we      = 1'b0;
      if (abort_next) begin
        bus.i_reg_we = 1'b1; bus.i_reg_addr = 4'd7; bus.i_reg_data = 8'h80;
        abort_next   = 1'b0;
      end else if (cyc == poke_at) begin
        bus.i_reg_we = 1'b1; bus.i_reg_addr = 4'd4; bus.i_reg_data = 8'h01;
      end
      #1;
      cur = int'({bus.o_dst_addr, bus.o_dst_data});
      if (bus.o_active) act++;
      if (bus.o_done) seen_done = 1'b1;
      if (bus.o_src_re) got_rd.push_back(int'(bus.o_src_addr));
      if (!bus.o_dst_we_b) begin
        got_wr.push_back(cur);
        strobes++;
        if (strobes == abort_at) abort_next = 1'b1;
        if (bus.i_free_vbus_b) stall_bad++;
      end else if (bus.i_free_vbus_b && cyc >= SRC_LAT + 1 && exp_wr.size() > 0 && cur != exp_wr[0]) begin
        stall_bad++;
      end
      if (!seen_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.i_reg_we      = 1'b0;
    bus.i_free_vbus_b = 1'b0;
    check({tag, " done_seen"}, seen_done, 1);
    check({tag, " wr_count"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check($sformatf("%s wr[%0d]", tag, i), got_wr[i], exp_wr[i]);
    check({tag, " rd_count"}, got_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
      check($sformatf("%s rd[%0d]", tag, i), got_rd[i], exp_rd[i]);
    check({tag, " active_cycles"}, act, exp_act);
    if (stall_until > 0) check({tag, " stall_hold"}, stall_bad, 0);
    @(negedge clk);
    #1;
    check({tag, " done_single"}, bus.o_done, 0);
    check({tag, " idle_after"}, bus.o_active, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.i_reg_we = 1'b0; bus.i_reg_addr = '0; bus.i_reg_data = '0;
    bus.i_free_vbus_b = 1'b0;
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    #1;
    check("reset src_re",   bus.o_src_re,   0);
    check("reset src_addr", bus.o_src_addr, 0);
    check("reset dst_we_b", bus.o_dst_we_b, 1);
    check("reset dst_addr", bus.o_dst_addr, 0);
    check("reset dst_data", bus.o_dst_data, 0);
    check("reset active",   bus.o_active,   0);
    check("reset done",     bus.o_done,     0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 25; i++) src_mem[i] = 8'(i);
    do_blit("copy5x5", 1, 16'h0000, 16'h1010, 5, 5, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 3);
    do_blit("rerun", 0, 16'h0000, 16'h1010, 5, 5, 0, 0, 8'hFF, 0, 0, 0, 0, 0, -1);
    do_blit("stride", 1, 16'h0000, 16'h2000, 4, 3, 2, 156, 8'hFF, 0, 0, 0, 0, 0, -1);
    do_blit("fill", 1, 16'h4000, 16'h3000, 3, 2, 0, 0, 8'h0F, 8'hA5, 1, 0, 0, 0, -1);
    src_mem[16'h0200] = 8'h00; src_mem[16'h0201] = 8'h11;
    src_mem[16'h0202] = 8'h00; src_mem[16'h0203] = 8'h22;
    do_blit("keycopy", 1, 16'h0200, 16'h3100, 4, 1, 0, 0, 8'hFF, 8'h00, 2, 0, 0, 0, -1);
    do_blit("stall", 1, 16'h0010, 16'h5000, 2, 1, 0, 0, 8'hFF, 0, 0, SRC_LAT + 5, 4, 0, -1);
    do_blit("wrap", 1, 16'h0040, 16'hFFFE, 4, 1, 0, 0, 8'hFF, 0, 0, 0, 0, 0, -1);
    do_blit("abort", 1, 16'h0080, 16'h6000, 5, 5, 0, 0, 8'hFF, 0, 0, 0, 0, 7, -1);

    program_regs(16'h0000, 16'h7000, 0, 3, 0, 0, 8'hFF, 0);
    reg_write(4'd7, 8'h01);
    #1;
    check("w0 done",   bus.o_done,     1);
    check("w0 active", bus.o_active,   0);
    check("w0 src_re", bus.o_src_re,   0);
    check("w0 we_b",   bus.o_dst_we_b, 1);
    @(negedge clk);
    #1;
    check("w0 done_single", bus.o_done, 0);

    program_regs(16'h0000, 16'h7100, 2, 2, 0, 0, 8'hFF, 0);
    reg_write(4'd7, 8'h81);
    #1;
    check("start_abort active", bus.o_active, 0);
    check("start_abort done",   bus.o_done,   0);
    @(negedge clk);
    #1;
    check("start_abort active2", bus.o_active, 0);
    check("start_abort done2",   bus.o_done,   0);

    program_regs(16'h0300, 16'h7200, 3, 1, 0, 0, 8'hFF, 0);
    reg_write(4'd7, 8'h01);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (!bus.o_dst_we_b) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid strobe_seen", found, 1);
    rst = 1'b1;
    #1;
    check("rst_mid we_b",     bus.o_dst_we_b, 1);
    check("rst_mid active",   bus.o_active,   0);
    check("rst_mid dst_addr", bus.o_dst_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      int rs, rdd, rw, rh, rss, rds, rm, rk, rmode;
      rs    = $urandom_range(0, 65535);
      rdd   = $urandom_range(0, 65535);
      rw    = $urandom_range(1, 6);
      rh    = $urandom_range(1, 4);
      rss   = $urandom_range(0, 10);
      rds   = $urandom_range(0, 10);
      rm    = $urandom_range(0, 255);
      rmode = $urandom_range(0, 3);
      rk    = (rmode == 2) ? int'(src_mem[rs]) : $urandom_range(0, 255);
      do_blit($sformatf("rand%0d", t), 1, rs, rdd, rw, rh, rss, rds, rm, rk, rmode, 0, 0, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vga_blit_engine.md
Name: vga_blit_engine

Overview:
Parametrised successor to the VGA DMA copier. It is a register-programmed 2-D blitter that moves a WIDTH x HEIGHT rectangle from CPU-side RAM into VRAM. It adds independent source and destination strides, a solid-fill mode, a transparent-key copy mode, abort, and vbus-grant stalling. It sits between the CPU RAM bus and the VRAM bus, and owns the VRAM write port while o_active is high.

Parameters:
ADDR_W, 16, width of source and destination addresses; all address arithmetic is modulo 2^ADDR_W.
DATA_W, 8, pixel/data width.
LEN_W, 8, width of WIDTH, HEIGHT and stride registers.
SRC_LAT, 1, cycles from o_src_re assertion to valid i_src_data (1..4).

Ports:
i_clk  in  1  system clock; all logic on rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_reg_we  in  1  register write strobe (one cycle).
i_reg_addr  in  4  register index.
i_reg_data  in  8  register write data.
o_src_re  out  1  source read request (active high).
o_src_addr  out  ADDR_W  source address.
i_src_data  in  DATA_W  source read data.
o_dst_we_b  out  1  VRAM write enable, active low.
o_dst_addr  out  ADDR_W  VRAM address.
o_dst_data  out  DATA_W  VRAM write data.
i_free_vbus_b  in  1  high means VRAM bus is reserved for the display, so the engine must stall.
o_active  out  1  engine owns buses.
o_done  out  1  one-cycle pulse at completion or abort.

Behaviour:
- Registers:
  - 0/1 SRC lo/hi, 2/3 DST lo/hi. Bits above ADDR_W are ignored.
  - 4 WIDTH, 5 HEIGHT, 6 MASK, 7 CTRL, 8 KEY (also the fill value), 9 SRC_STRIDE, 10 DST_STRIDE. Indices 11-15 are ignored.
  - CTRL bit0 START (self-clearing), bits2:1 MODE (0 copy, 1 fill, 2 key-copy, 3 reserved = copy), bit7 ABORT.
  - Reset values: stride registers 0, all other registers 0.
- Writes while o_active: only CTRL.ABORT is honoured; all other writes are dropped.
- Reset values of outputs: o_src_re=0, o_src_addr=0, o_dst_we_b=1, o_dst_addr=0, o_dst_data=0, o_active=0, o_done=0.
- START latch: on START, the engine latches SRC, DST, W, H, MASK, KEY, MODE and both strides into working copies. Later register writes do not affect a running blit.
- FSM: IDLE -> READ -> WAIT -> WRITE -> ADV -> (READ | DONE) -> IDLE.
  - IDLE: START with W=0 or H=0 -> DONE directly (no bus cycles, o_done pulses 1 cycle after START write). Otherwise o_active rises the cycle after the START write.
  - READ: o_src_re=1 for 1 cycle with o_src_addr = current source pointer. Skipped in fill mode (go to WRITE).
  - WAIT: SRC_LAT cycles; i_src_data is captured at the end of the last WAIT cycle.
  - WRITE: o_dst_addr = dst pointer; o_dst_data = (copy/key ? captured : KEY) & MASK; o_dst_we_b=0 for exactly 1 cycle.
    - If i_free_vbus_b=1 on entering WRITE, hold in WRITE with o_dst_we_b=1 until it drops; address and data stay stable.
    - Key mode: if captured data == KEY (compared before masking), no write strobe occurs and the cycle still counts.
  - ADV: column++, src++, dst++. When column reaches W:
    - column=0, row++;
    - src_row += W + SRC_STRIDE, dst_row += W + DST_STRIDE (stride = gap bytes after each row);
    - pointers reload from the row bases.
    - row reaching H -> DONE.
  - DONE: o_done=1 one cycle, o_active=0 in the same cycle, return to IDLE.
- Throughput, unstalled: copy/key = 3+SRC_LAT-1+1 = SRC_LAT+3 cycles/pixel; fill = 2 cycles/pixel (WRITE, ADV).
- ABORT: takes effect at the next cycle boundary from any busy state. An in-progress WRITE strobe completes first; no further strobes follow. Then DONE (o_done pulses).
- START while busy is ignored. START and ABORT in the same write while idle: ABORT wins, nothing starts, no o_done.
- Address wrap: pointers wrap modulo 2^ADDR_W silently.
- Reset mid-operation: immediately returns to IDLE with all outputs at their reset values; no partial strobe is extended.

Test Plan:
- Copy, SRC=0x0000, DST=0x1010, W=5, H=5, strides 0, MASK=0xFF, source RAM holds i at addr i -> 25 writes; DST 0x1010..0x1028 get 0x00..0x18; o_done pulses once; 25*(SRC_LAT+3) cycles active.
- Strided copy, W=4, H=3, SRC_STRIDE=2, DST_STRIDE=156 -> destination rows start at DST, DST+160, DST+320; source reads at 0-3, 6-9, 12-15.
- Fill mode, KEY=0xA5, MASK=0x0F, W=3, H=2 -> 6 writes of 0x05; o_src_re never asserts; 12 active cycles.
- Key-copy, KEY=0x00, source pattern 00,11,00,22 in a 4x1 blit -> exactly 2 strobes (addr +1 = 0x11, +3 = 0x22).
- Stall: hold i_free_vbus_b=1 for 4 cycles entering the first WRITE -> o_dst_we_b stays 1, addr/data stable, write completes after release; the total is 4 cycles longer.
- Edge cases:
  - W=0 -> o_done one cycle after START with no bus activity.
  - ABORT after 7 pixels of a 5x5 blit -> exactly 7 strobes, then o_done.
  - i_rst asserted mid-WRITE -> o_dst_we_b=1 and o_active=0 immediately.
  - DST=0xFFFE, W=4 -> writes land at FFFE, FFFF, 0000, 0001.
